// File: rtl/vending_pkg.sv
// Shared types and the coin denomination table for the change dispenser.
// Coin codes run largest-first so a lower code always means a larger coin.
package vending_pkg;

    localparam int unsigned NUM_COINS    = 6;
    localparam int unsigned COIN_W       = 3;
    localparam int unsigned COIN_VALUE_W = 9;

    localparam logic [COIN_W-1:0] COIN_500 = 3'd0;
    localparam logic [COIN_W-1:0] COIN_100 = 3'd1;
    localparam logic [COIN_W-1:0] COIN_25  = 3'd2;
    localparam logic [COIN_W-1:0] COIN_10  = 3'd3;
    localparam logic [COIN_W-1:0] COIN_5   = 3'd4;
    localparam logic [COIN_W-1:0] COIN_1   = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SELECT,
        S_OFFER,
        S_DONE
    } state_e;

    // Value in cents of a coin code; unused codes map to zero.
    function automatic logic [COIN_VALUE_W-1:0] coin_value(input logic [COIN_W-1:0] code);
        logic [COIN_VALUE_W-1:0] value;
        case (code)
            COIN_500: value = 9'd500;
            COIN_100: value = 9'd100;
            COIN_25:  value = 9'd25;
            COIN_10:  value = 9'd10;
            COIN_5:   value = 9'd5;
            COIN_1:   value = 9'd1;
            default:  value = 9'd0;
        endcase
        return value;
    endfunction

endpackage

// File: rtl/coin_picker.sv
// Combinational priority selector: largest available coin whose value fits
// in the remaining amount.
module coin_picker
    import vending_pkg::*;
#(
    parameter int unsigned AMOUNT_W = 16
) (
    input  logic [AMOUNT_W-1:0]  remain_i,
    input  logic [NUM_COINS-1:0] avail_i,
    output logic                 found_o,
    output logic [COIN_W-1:0]    code_o
);

    localparam int unsigned CMP_W = (AMOUNT_W > COIN_VALUE_W) ? AMOUNT_W : COIN_VALUE_W;

    always_comb begin
        found_o = 1'b0;
        code_o  = COIN_500;
        // Scan smallest to largest so the last hit, the largest fitting coin, wins.
        for (int i = NUM_COINS - 1; i >= 0; i--) begin
            if (avail_i[i] &&
                (CMP_W'(coin_value(COIN_W'(i))) <= CMP_W'(remain_i))) begin
                found_o = 1'b1;
                code_o  = COIN_W'(i);
            end
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Greedy change dispenser: splits an amount into coins and offers them one at a
// time to the hopper. Define COIN_INVENTORY_EN to track per-denomination stock.
module change_dispenser
    import vending_pkg::*;
#(
    parameter int unsigned AMOUNT_W   = 16,
    parameter int unsigned COUNT_W    = 8,
    parameter int unsigned INIT_STOCK = 20
) (
    input  logic                I_CLK,
    input  logic                I_RESET,
    input  logic                I_START,
    input  logic [AMOUNT_W-1:0] I_AMOUNT,
    input  logic                I_COIN_ACK,
    input  logic                I_REFILL,
    output logic                O_BUSY,
    output logic                O_COIN_VALID,
    output logic [2:0]          O_COIN_SEL,
    output logic [AMOUNT_W-1:0] O_REMAIN,
    output logic [COUNT_W-1:0]  O_COIN_COUNT,
    output logic                O_DONE,
    output logic                O_SHORT
);

    state_e                state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  valid_q, valid_d;
    logic [COIN_W-1:0]     sel_q, sel_d;
    logic [AMOUNT_W-1:0]   remain_q, remain_d;
    logic [COUNT_W-1:0]    count_q, count_d;
    logic                  short_q, short_d;

    logic [NUM_COINS-1:0]  avail;
    logic                  pick_found;
    logic [COIN_W-1:0]     pick_code;
    logic                  ack_take;
    logic [AMOUNT_W-1:0]   sel_value;

    assign ack_take  = (state_q == S_OFFER) && I_COIN_ACK;
    assign sel_value = AMOUNT_W'(coin_value(sel_q));

`ifdef COIN_INVENTORY_EN
    localparam int unsigned STOCK_W = $clog2(INIT_STOCK + 1);

    logic [STOCK_W-1:0] stock_q [NUM_COINS];

    // Refill shares the reset path so it wins over a same-cycle ack.
    always_ff @(posedge I_CLK) begin
        if (I_RESET || I_REFILL) begin
            for (int i = 0; i < NUM_COINS; i++) begin
                stock_q[i] <= STOCK_W'(INIT_STOCK);
            end
        end else if (ack_take) begin
            stock_q[sel_q] <= stock_q[sel_q] - STOCK_W'(1);
        end
    end

    always_comb begin
        avail = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            avail[i] = (stock_q[i] != '0);
        end
    end

    assign O_SHORT = short_q;
`else
    logic unused_cfg;

    assign avail      = {NUM_COINS{1'b1}};
    assign O_SHORT    = 1'b0;
    assign unused_cfg = ^{I_REFILL, short_q, 1'(INIT_STOCK)};
`endif

    coin_picker #(
        .AMOUNT_W(AMOUNT_W)
    ) u_coin_picker (
        .remain_i(remain_q),
        .avail_i (avail),
        .found_o (pick_found),
        .code_o  (pick_code)
    );

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            sel_q    <= COIN_500;
            remain_q <= '0;
            count_q  <= '0;
            short_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            sel_q    <= sel_d;
            remain_q <= remain_d;
            count_q  <= count_d;
            short_q  <= short_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        valid_d  = valid_q;
        sel_d    = sel_q;
        remain_d = remain_q;
        count_d  = count_q;
        short_d  = short_q;

        case (state_q)
            S_IDLE: begin
                if (I_START) begin
                    remain_d = I_AMOUNT;
                    count_d  = '0;
                    short_d  = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = S_SELECT;
                end
            end
            S_SELECT: begin
                // A zero remainder never finds a coin, so it also lands in S_DONE.
                if (pick_found) begin
                    sel_d   = pick_code;
                    valid_d = 1'b1;
                    state_d = S_OFFER;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_OFFER: begin
                if (ack_take) begin
                    remain_d = remain_q - sel_value;
                    if (count_q != {COUNT_W{1'b1}}) begin
                        count_d = count_q + COUNT_W'(1);
                    end
                    valid_d = 1'b0;
                    state_d = S_SELECT;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                short_d = (remain_q != '0);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign O_BUSY       = busy_q;
    assign O_COIN_VALID = valid_q;
    assign O_COIN_SEL   = sel_q;
    assign O_REMAIN     = remain_q;
    assign O_COIN_COUNT = count_q;
    assign O_DONE       = (state_q == S_DONE);

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a greedy model predicts the coin
// sequence and final totals, which are compared as the hopper acks coins.
module tb_change_dispenser;

`ifdef COIN_INVENTORY_EN
    localparam int unsigned STOCK = 1;
    localparam bit          INV   = 1'b1;
`else
    localparam int unsigned STOCK = 20;
    localparam bit          INV   = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] amount;
    logic        ack;
    logic        refill;
    logic        busy;
    logic        valid;
    logic [2:0]  sel;
    logic [15:0] remain;
    logic [7:0]  count;
    logic        done;
    logic        short_flag;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int unsigned val_tbl [6] = '{500, 100, 25, 10, 5, 1};
    int          stock_m [6];
    int          q_exp [$];
    int          exp_rem;
    int          exp_cnt;
    bit          exp_short;

    change_dispenser #(
        .AMOUNT_W  (16),
        .COUNT_W   (8),
        .INIT_STOCK(STOCK)
    ) dut (
        .I_CLK       (clk),
        .I_RESET     (rst),
        .I_START     (start),
        .I_AMOUNT    (amount),
        .I_COIN_ACK  (ack),
        .I_REFILL    (refill),
        .O_BUSY      (busy),
        .O_COIN_VALID(valid),
        .O_COIN_SEL  (sel),
        .O_REMAIN    (remain),
        .O_COIN_COUNT(count),
        .O_DONE      (done),
        .O_SHORT     (short_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void init_stock_model();
        for (int d = 0; d < 6; d++) stock_m[d] = INV ? int'(STOCK) : 1000000;
    endfunction

    function automatic void predict(input int amt);
        int rem = amt;
        q_exp.delete();
        exp_cnt = 0;
        for (int d = 0; d < 6; d++) begin
            while (rem >= int'(val_tbl[d]) && stock_m[d] > 0) begin
                q_exp.push_back(d);
                rem -= int'(val_tbl[d]);
                exp_cnt++;
                if (INV) stock_m[d]--;
            end
        end
        exp_rem   = rem;
        exp_short = INV && (rem != 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_refill();
        refill = 1'b1;
        tick();
        refill = 1'b0;
        if (INV) init_stock_model();
    endtask

    // Called just after a clock edge; returns just after the cycle following O_DONE.
    task automatic run_job(input int amt, input int delay, input bit mid_start, input bit done_start);
        int c0, ack_cyc, wait_cnt, budget, run_rem;
        bit first, after_ack, got_done, new_coin;
        logic [2:0] held;
        predict(amt);
        run_rem   = amt;
        c0        = cyc;
        amount    = 16'(amt);
        start     = 1'b1;
        tick();
        start     = 1'b0;
        amount    = ~16'(amt);
        check_eq("busy_after_start", 32'(busy), 32'd1);
        first     = 1'b1;
        after_ack = 1'b0;
        got_done  = 1'b0;
        new_coin  = 1'b1;
        wait_cnt  = 0;
        budget    = 0;
        ack_cyc   = 0;
        held      = '0;
        while (!got_done && budget < 2000) begin
            tick();
            budget++;
            ack   = 1'b0;
            start = 1'b0;
            if (after_ack) begin
                check_eq("valid_gap", 32'(valid), 32'd0);
                after_ack = 1'b0;
            end else if (done) begin
                got_done = 1'b1;
                if (amt == 0) check_eq("zero_done_latency", 32'(cyc), 32'(c0 + 2));
                check_eq("final_remain", 32'(remain), 32'(exp_rem));
                check_eq("final_count", 32'(count), 32'(exp_cnt));
                check_eq("coins_missing", 32'(q_exp.size()), 32'd0);
                if (done_start) begin
                    start  = 1'b1;
                    amount = 16'd25;
                end
            end else if (valid) begin
                if (new_coin) begin
                    if (first) begin
                        check_eq("first_valid_latency", 32'(cyc), 32'(c0 + 2));
                        check_eq("count_cleared", 32'(count), 32'd0);
                    end else begin
                        check_eq("next_valid_latency", 32'(cyc), 32'(ack_cyc + 2));
                    end
                    check_eq("remain_track", 32'(remain), 32'(run_rem));
                    first    = 1'b0;
                    new_coin = 1'b0;
                    held     = sel;
                end else begin
                    check_eq("sel_stable", 32'(sel), 32'(held));
                end
                if (mid_start && wait_cnt == 1) begin
                    start  = 1'b1;
                    amount = 16'd5;
                end
                if (wait_cnt >= delay) begin
                    if (q_exp.size() > 0) begin
                        check_eq("coin_sel", 32'(sel), 32'(q_exp[0]));
                        run_rem -= int'(val_tbl[q_exp[0]]);
                        void'(q_exp.pop_front());
                    end else begin
                        check_eq("extra_coin", 32'(q_exp.size()), 32'd1);
                    end
                    ack       = 1'b1;
                    ack_cyc   = cyc;
                    after_ack = 1'b1;
                    new_coin  = 1'b1;
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end
        end
        check_eq("job_done_seen", 32'(got_done), 32'd1);
        tick();
        start  = 1'b0;
        amount = 16'd0;
        check_eq("done_one_cycle", 32'(done), 32'd0);
        check_eq("busy_clear", 32'(busy), 32'd0);
        check_eq("short_flag", 32'(short_flag), 32'(exp_short));
        check_eq("remain_held", 32'(remain), 32'(exp_rem));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_valid"}, 32'(valid), 32'd0);
        check_eq({tag, "_sel"}, 32'(sel), 32'd0);
        check_eq({tag, "_remain"}, 32'(remain), 32'd0);
        check_eq({tag, "_count"}, 32'(count), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_short"}, 32'(short_flag), 32'd0);
    endtask

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        rst    = 1'b1;
        start  = 1'b0;
        amount = '0;
        ack    = 1'b0;
        refill = 1'b0;
        init_stock_model();
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_reset_outputs("reset");

        // Stray acks while idle must not move anything.
        ack = 1'b1;
        tick();
        tick();
        ack = 1'b0;
        check_eq("ack_idle_remain", 32'(remain), 32'd0);
        check_eq("ack_idle_count", 32'(count), 32'd0);

        run_job(150, 0, 1'b0, 1'b1);
        do_refill();
        run_job(641, 0, 1'b0, 1'b0);
        do_refill();
        run_job(0, 0, 1'b0, 1'b0);
        run_job(200, 4, 1'b1, 1'b0);
        run_job(10, 0, 1'b0, 1'b0);

        // Reset while a coin is on offer aborts the job with no done pulse.
        amount = 16'd500;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        waited = 0;
        while (!valid && waited < 20) begin
            tick();
            waited++;
        end
        check_eq("abort_offer_sel", 32'(sel), 32'd0);
        check_eq("abort_offer_valid", 32'(valid), 32'd1);
        rst = 1'b1;
        tick();
        check_reset_outputs("abort");
        rst = 1'b0;
        init_stock_model();
        tick();
        check_eq("abort_no_done", 32'(done), 32'd0);

`ifdef COIN_INVENTORY_EN
        do_refill();
        run_job(60, 1, 1'b0, 1'b0);
        check_eq("inv_short_60", 32'(short_flag), 32'd1);
        check_eq("inv_remain_60", 32'(remain), 32'd19);
        do_refill();
        run_job(19, 0, 1'b0, 1'b0);
        check_eq("inv_remain_19", 32'(remain), 32'd3);
        do_refill();
`endif

        for (int j = 0; j < 6; j++) begin
            if (j % 2 == 0) do_refill();
            run_job(int'($urandom_range(0, 1200)), int'($urandom_range(0, 2)), 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
